// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding, reset
// vector, NOP encoding and the RV32I major opcodes decode already relies on.
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_BUF   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;

    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_JAL    = 7'h6F;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched word with its PC, drop the valid
// flag when decode advances without a new word, otherwise hold.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_advance,
    input  logic [31:0]           i_instr,
    input  logic [ADDR_WIDTH-1:0] i_pc,
    output logic                  o_valid,
    output logic [31:0]           o_instr,
    output logic [ADDR_WIDTH-1:0] o_pc,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_instr    <= INSTR_NOP;
            o_pc       <= RESET_PC;
            o_pc_plus4 <= RESET_PC + ADDR_WIDTH'(4);
        end else if (i_load) begin
            o_valid    <= 1'b1;
            o_instr    <= i_instr;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc + ADDR_WIDTH'(4);
        end else if (i_advance) begin
            o_valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction fetch: PC, single-outstanding req/gnt/rvalid master,
// one-entry skid buffer and branch redirect with wrong-path squash.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  PCsrc,
    input  logic [31:0]           ImmExt,
    input  logic                  stall,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    output logic                  id_valid,
    output logic [31:0]           id_instr,
    output logic [ADDR_WIDTH-1:0] id_pc,
    output logic [ADDR_WIDTH-1:0] id_pc_plus4,
    output logic [6:0]            opcode,
    output logic [2:0]            funct3,
    output logic                  funct7
);

    fetch_state_t          r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_req_pc;
    logic                  r_kill;
    logic [31:0]           r_buf_instr;
    logic [ADDR_WIDTH-1:0] r_buf_pc;

    logic                  w_redirect;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_ifid_free;
    logic                  w_load;
    logic [31:0]           w_load_instr;
    logic [ADDR_WIDTH-1:0] w_load_pc;

    assign w_redirect  = PCsrc && id_valid && !stall;
    assign w_target    = id_pc + ImmExt[ADDR_WIDTH-1:0];
    assign w_ifid_free = !id_valid || !stall;

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;

    // A redirect always suppresses the IF/ID load: the word belongs to the old path.
    always_comb begin
        w_load       = 1'b0;
        w_load_instr = imem_rdata;
        w_load_pc    = r_req_pc;
        case (r_state)
            S_WAIT: w_load = imem_rvalid && !r_kill && !w_redirect && w_ifid_free;
            S_BUF: begin
                w_load       = !stall && !w_redirect;
                w_load_instr = r_buf_instr;
                w_load_pc    = r_buf_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_kill      <= 1'b0;
            r_buf_instr <= '0;
            r_buf_pc    <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_gnt) begin
                        r_req_pc <= r_pc;
                        r_pc     <= w_redirect ? w_target : r_pc + ADDR_WIDTH'(4);
                        r_kill   <= w_redirect;
                        r_state  <= S_WAIT;
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                    end
                end
                S_WAIT: begin
                    if (w_redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_rvalid) begin
                        r_kill <= 1'b0;
                        if (r_kill || w_redirect || w_ifid_free) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_buf_instr <= imem_rdata;
                            r_buf_pc    <= r_req_pc;
                            r_state     <= S_BUF;
                        end
                    end else if (w_redirect) begin
                        r_kill <= 1'b1;
                    end
                end
                S_BUF: begin
                    if (w_redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (!stall) begin
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_advance  (!stall),
        .i_instr    (w_load_instr),
        .i_pc       (w_load_pc),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc       (id_pc),
        .o_pc_plus4 (id_pc_plus4)
    );

    assign opcode = id_instr[6:0];
    assign funct3 = id_instr[14:12];
    assign funct7 = id_instr[30];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the pipelined RV32I core, directly upstream of the control unit. Holds the PC and issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake. Registers each returned word with its PC into the IF/ID register, which drives opcode/funct3/funct7 into decode. Takes the decode-stage branch decision (PCsrc, ImmExt) to redirect the PC and squash wrong-path fetches.

## Interface
- ADDR_WIDTH, 32, PC / instruction-memory address width
- RESET_PC, 32'hBFC00000, first fetch address after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- PCsrc  in  1  redirect request from decode; sampled only when id_valid && !stall
- ImmExt  in  32  sign-extended branch offset; target = id_pc + ImmExt
- stall  in  1  decode cannot accept; IF/ID holds
- imem_req  out  1  request valid
- imem_addr  out  ADDR_WIDTH  request address, stable while imem_req && !imem_gnt
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  read data valid; ≥1 cycle after gnt, exactly once per grant
- imem_rdata  in  32  instruction word
- id_valid  out  1  IF/ID holds a live instruction
- id_instr  out  32  IF/ID instruction
- id_pc, id_pc_plus4  out  ADDR_WIDTH  PC of id_instr and PC+4
- opcode[6:0], funct3[2:0], funct7  out  id_instr[6:0], [14:12], bit 30

## Operation
- States: FETCH, WAIT, BUF.
- FETCH: imem_req=1, imem_addr=pc. On gnt: req_pc<=pc, pc<=pc+4, go WAIT.
- WAIT: on rvalid: if kill set, drop data, clear kill, go FETCH. Else if IF/ID free (!id_valid or !stall), load IF/ID {rdata, req_pc}, go FETCH; else store in 1-entry skid buffer, go BUF.
- BUF: imem_req=0. When !stall, move buffer into IF/ID, go FETCH.
- Redirect (PCsrc && id_valid && !stall): pc<=id_pc+ImmExt (mod 2^ADDR_WIDTH); id_valid<=0 next cycle.
  - In FETCH with gnt same cycle: the granted request is wrong-path; set kill, go WAIT; pc still loads the target, not pc+4.
  - In WAIT: set kill (rvalid same cycle: drop data, go FETCH).
  - In BUF: discard buffer, go FETCH.
- Redirect beats normal IF/ID load in the same cycle.
- IF/ID advance with !stall and no new word: id_valid<=0.
- stall with id_valid=0 has no effect on IF/ID.
- Target alignment not checked; bits [1:0] pass through.

## Timing
- Reset (async assert): state=FETCH, pc=RESET_PC, req_pc=RESET_PC, kill=0, id_valid=0, id_instr=32'h00000013 (nop), id_pc=RESET_PC, id_pc_plus4=RESET_PC+4, skid buffer cleared. imem_req=1 in first cycle after rst_n deasserts.
- Best case: gnt in cycle N, rvalid in N+1, id_valid high in N+2. Sustained 1 instruction per 2 cycles.
- Redirect in cycle N: first correct-path request at pc target no later than N+1 (FETCH) or the cycle after the killed rvalid.
- rst_n asserted mid-transaction: outstanding rvalid after reset release must not arrive (memory is reset together); no tracking required.
- Outputs opcode/funct3/funct7 are combinational slices of registered id_instr.

## Structure
- Shared package: fetch state enum, RESET_PC default, NOP encoding 32'h00000013, opcode constants already used by decode.
- One sub-module natural: if_id_reg (IF/ID register with load/flush/hold, async reset). Skid buffer and FSM stay in fetch_stage.

## Test plan
- Reset release, memory with gnt=1, rvalid 1 cycle later returning 0x00500093 -> imem_addr=0xBFC00000, id_valid high two cycles after grant, id_pc=0xBFC00000, opcode=0x13, funct3=0.
- Three consecutive fetches -> id_pc 0xBFC00000, 0xBFC00004, 0xBFC00008 in order, 2 cycles apart.
- stall high for 4 cycles while a word returns -> word held in BUF, imem_req=0, IF/ID unchanged. On stall low, next instruction appears exactly once, nothing lost or duplicated.
- bne in ID with PCsrc=1, id_pc=0xBFC00010, ImmExt=-8, while fetch of 0xBFC00014 is in WAIT -> that response dropped, next imem_addr=0xBFC00008, no id_valid for 0xBFC00014.
- gnt delayed 3 cycles -> imem_addr stable 0xBFC00004 throughout; pc not incremented until gnt.
- rst_n pulsed low while in BUF -> id_valid=0 and pc=0xBFC00000 immediately (asynchronously), fetch restarts at RESET_PC.
